// File: rtl/alu_8bit_pkg.sv
// Shared definitions for the 8-bit ALU: the operand width and the 4-bit
// opcode enumeration (OP_ADD..OP_EQ). All 16 opcode values are defined.
package alu_8bit_pkg;

  localparam int WIDTH = 8;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_MUL  = 4'h2,
    OP_DIV  = 4'h3,
    OP_SHL  = 4'h4,
    OP_SHR  = 4'h5,
    OP_ROL  = 4'h6,
    OP_ROR  = 4'h7,
    OP_AND  = 4'h8,
    OP_OR   = 4'h9,
    OP_XOR  = 4'hA,
    OP_NOR  = 4'hB,
    OP_NAND = 4'hC,
    OP_XNOR = 4'hD,
    OP_GT   = 4'hE,
    OP_EQ   = 4'hF
  } op_e;

endpackage

// File: rtl/alu_8bit_if.sv
// Operand/result bus of the 8-bit ALU.
//   operand_a, operand_b : unsigned operands (driven by master)
//   operation            : 4-bit opcode (driven by master)
//   result, carry_out    : registered outputs (driven by slave)
//   zero_flag, overflow_flag : registered status, present only when the
//                          ALU_FLAGS_EN macro is defined
interface alu_8bit_if;
  import alu_8bit_pkg::*;

  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic [3:0]       operation;
  logic [WIDTH-1:0] result;
  logic             carry_out;
`ifdef ALU_FLAGS_EN
  logic             zero_flag;
  logic             overflow_flag;
`endif

  modport master (
    output operand_a, operand_b, operation,
`ifdef ALU_FLAGS_EN
    input  zero_flag, overflow_flag,
`endif
    input  result, carry_out
  );

  modport slave (
    input  operand_a, operand_b, operation,
`ifdef ALU_FLAGS_EN
    output zero_flag, overflow_flag,
`endif
    output result, carry_out
  );

endinterface

// File: rtl/alu_8bit_core.sv
// Combinational datapath of the 8-bit ALU: computes the next result,
// carry/borrow/status bit and (with ALU_FLAGS_EN) the zero and
// two's-complement overflow flags from the current operands and opcode.
//   a, b          : operands
//   op            : opcode
//   result_next   : next result value
//   carry_next    : next carry_out value
//   zero_next, overflow_next : next flag values (ALU_FLAGS_EN only)
module alu_8bit_core
  import alu_8bit_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
`ifdef ALU_FLAGS_EN
  output logic             zero_next,
  output logic             overflow_next,
`endif
  output logic [WIDTH-1:0] result_next,
  output logic             carry_next
);

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    sum         = {1'b0, a} + {1'b0, b};
    // The 9th bit of the widened difference is the borrow (set when a < b).
    diff        = {1'b0, a} - {1'b0, b};
    prod        = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    result_next = '0;
    carry_next  = 1'b0;
    case (op)
      OP_ADD:  {carry_next, result_next} = sum;
      OP_SUB:  {carry_next, result_next} = diff;
      OP_MUL: begin
        result_next = prod[WIDTH-1:0];
        carry_next  = |prod[2*WIDTH-1:WIDTH];
      end
      OP_DIV: begin
        if (b == '0) begin
          result_next = '1;
          carry_next  = 1'b1;
        end else begin
          result_next = a / b;
        end
      end
      OP_SHL: begin
        result_next = {a[WIDTH-2:0], 1'b0};
        carry_next  = a[WIDTH-1];
      end
      OP_SHR: begin
        result_next = {1'b0, a[WIDTH-1:1]};
        carry_next  = a[0];
      end
      OP_ROL: begin
        result_next = {a[WIDTH-2:0], a[WIDTH-1]};
        carry_next  = a[WIDTH-1];
      end
      OP_ROR: begin
        result_next = {a[0], a[WIDTH-1:1]};
        carry_next  = a[0];
      end
      OP_AND:  result_next = a & b;
      OP_OR:   result_next = a | b;
      OP_XOR:  result_next = a ^ b;
      OP_NOR:  result_next = ~(a | b);
      OP_NAND: result_next = ~(a & b);
      OP_XNOR: result_next = ~(a ^ b);
      OP_GT:   result_next = {{(WIDTH-1){1'b0}}, (a > b)};
      OP_EQ:   result_next = {{(WIDTH-1){1'b0}}, (a == b)};
      default: result_next = '0;
    endcase
  end

`ifdef ALU_FLAGS_EN
  // Signed overflow: ADD overflows when like-signed operands give a result of
  // the other sign; SUB when unlike-signed operands give a result whose sign
  // differs from a.
  always_comb begin
    zero_next     = (result_next == '0);
    overflow_next = 1'b0;
    if (op == OP_ADD)
      overflow_next = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    else if (op == OP_SUB)
      overflow_next = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
  end
`endif

endmodule

// File: rtl/alu_8bit.sv
// 8-bit registered ALU. Operands and opcode are sampled every rising edge;
// outputs present the result one cycle later (throughput 1 per cycle).
// Optional feature macro: ALU_FLAGS_EN adds registered zero_flag and
// overflow_flag outputs on the bus.
//   clk : clock
//   rst : synchronous active-high reset; clears all outputs, wins over
//         any operation sampled on the same edge
//   bus : operand/opcode inputs and registered outputs (slave side)
module alu_8bit
  import alu_8bit_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  alu_8bit_if.slave  bus
);

  logic [WIDTH-1:0] result_next;
  logic             carry_next;
`ifdef ALU_FLAGS_EN
  logic             zero_next;
  logic             overflow_next;
`endif

  alu_8bit_core u_core (
    .a             (bus.operand_a),
    .b             (bus.operand_b),
    .op            (op_e'(bus.operation)),
`ifdef ALU_FLAGS_EN
    .zero_next     (zero_next),
    .overflow_next (overflow_next),
`endif
    .result_next   (result_next),
    .carry_next    (carry_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.result    <= '0;
      bus.carry_out <= 1'b0;
`ifdef ALU_FLAGS_EN
      bus.zero_flag     <= 1'b0;
      bus.overflow_flag <= 1'b0;
`endif
    end else begin
      bus.result    <= result_next;
      bus.carry_out <= carry_next;
`ifdef ALU_FLAGS_EN
      bus.zero_flag     <= zero_next;
      bus.overflow_flag <= overflow_next;
`endif
    end
  end

endmodule

// File: tb/tb_alu_8bit.sv
// Self-checking bench for alu_8bit: directed cases from the requirement
// list plus a 1000-cycle randomized back-to-back run with a mid-stream
// reset, checked against an integer-arithmetic reference model.
module tb_alu_8bit;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  alu_8bit_if bus ();

  alu_8bit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model using plain integer arithmetic.
  function automatic void ref_model(input int a, input int b, input int op,
                                    output int res, output int cy, output int ovf);
    int sa, sb, s;
    sa  = (a >= 128) ? a - 256 : a;
    sb  = (b >= 128) ? b - 256 : b;
    res = 0; cy = 0; ovf = 0;
    case (op)
      0:  begin s = a + b; res = s % 256; cy = (s > 255) ? 1 : 0;
                s = sa + sb; ovf = (s > 127 || s < -128) ? 1 : 0; end
      1:  begin res = (a - b + 256) % 256; cy = (a < b) ? 1 : 0;
                s = sa - sb; ovf = (s > 127 || s < -128) ? 1 : 0; end
      2:  begin s = a * b; res = s % 256; cy = (s >= 256) ? 1 : 0; end
      3:  begin if (b == 0) begin res = 255; cy = 1; end else res = a / b; end
      4:  begin res = (a * 2) % 256; cy = a / 128; end
      5:  begin res = a / 2; cy = a % 2; end
      6:  begin res = (a * 2) % 256 + a / 128; cy = a / 128; end
      7:  begin res = a / 2 + (a % 2) * 128; cy = a % 2; end
      8:  res = a & b;
      9:  res = a | b;
      10: res = a ^ b;
      11: res = 255 - (a | b);
      12: res = 255 - (a & b);
      13: res = 255 - (a ^ b);
      14: res = (a > b) ? 1 : 0;
      default: res = (a == b) ? 1 : 0;
    endcase
  endfunction

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    bus.operand_a = a;
    bus.operand_b = b;
    bus.operation = op;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(8'hFF, 8'hFF, 4'h0);
      n_checks++;
      if (bus.result !== 8'h00 || bus.carry_out !== 1'b0) begin
        n_fail++;
        $display("FAIL reset cycle %0d: result=%h carry=%b expected result=00 carry=0",
                 i, bus.result, bus.carry_out);
      end
`ifdef ALU_FLAGS_EN
      n_checks++;
      if (bus.zero_flag !== 1'b0 || bus.overflow_flag !== 1'b0) begin
        n_fail++;
        $display("FAIL reset flags: zero=%b ovf=%b expected 0 0", bus.zero_flag, bus.overflow_flag);
      end
`endif
    end
    // First edge after release computes normally.
    rst = 1'b0;
    drive(8'hFF, 8'hFF, 4'h0);
    n_checks++;
    if (bus.result !== 8'hFE || bus.carry_out !== 1'b1) begin
      n_fail++;
      $display("FAIL reset release: result=%h carry=%b expected result=fe carry=1",
               bus.result, bus.carry_out);
    end
  endtask

  // Directed table: a, b, op, expected result, carry, zero, overflow.
  task automatic test_directed();
    logic [7:0] ta [13] = '{8'h33, 8'hFF, 8'h10, 8'h7F, 8'h10, 8'h20, 8'h64,
                            8'h81, 8'h01, 8'h5A, 8'h05, 8'h80, 8'h80};
    logic [7:0] tb [13] = '{8'hCC, 8'h01, 8'h20, 8'h01, 8'h10, 8'h00, 8'h07,
                            8'hA5, 8'h3C, 8'h5A, 8'h06, 8'h01, 8'h80};
    logic [3:0] top [13] = '{4'h0, 4'h0, 4'h1, 4'h0, 4'h2, 4'h3, 4'h3,
                             4'h4, 4'h7, 4'hF, 4'hE, 4'h1, 4'h0};
    logic [7:0] tres [13] = '{8'hFF, 8'h00, 8'hF0, 8'h80, 8'h00, 8'hFF, 8'h0E,
                              8'h02, 8'h80, 8'h01, 8'h00, 8'h7F, 8'h00};
    logic tcy [13]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
                        1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic tz [13]   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic tov [13]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 13; i++) begin
      drive(ta[i], tb[i], top[i]);
      n_checks++;
      if (bus.result !== tres[i] || bus.carry_out !== tcy[i]) begin
        n_fail++;
        $display("FAIL directed %0d op=%h a=%h b=%h: result=%h carry=%b expected result=%h carry=%b",
                 i, top[i], ta[i], tb[i], bus.result, bus.carry_out, tres[i], tcy[i]);
      end
`ifdef ALU_FLAGS_EN
      n_checks++;
      if (bus.zero_flag !== tz[i] || bus.overflow_flag !== tov[i]) begin
        n_fail++;
        $display("FAIL directed flags %0d: zero=%b ovf=%b expected zero=%b ovf=%b",
                 i, bus.zero_flag, bus.overflow_flag, tz[i], tov[i]);
      end
`else
      if (tz[i] === 1'bx || tov[i] === 1'bx) $display("note: table entry %0d undefined", i);
`endif
    end
  endtask

  // Every opcode with random operands; shifts/rotates also check b is ignored.
  task automatic test_all_ops();
    int a, b, res, cy, ovf;
    for (int op = 0; op < 16; op++) begin
      for (int k = 0; k < 8; k++) begin
        a = int'($urandom_range(0, 255));
        b = (k == 0) ? 0 : int'($urandom_range(0, 255));
        ref_model(a, b, op, res, cy, ovf);
        drive(8'(a), 8'(b), 4'(op));
        n_checks++;
        if (bus.result !== 8'(res) || bus.carry_out !== 1'(cy)) begin
          n_fail++;
          $display("FAIL op_sweep op=%0h a=%h b=%h: result=%h carry=%b expected result=%h carry=%b",
                   op, a[7:0], b[7:0], bus.result, bus.carry_out, res[7:0], cy[0]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int a, b, op, res, cy, ovf;
    logic do_rst;
    for (int i = 0; i < 1000; i++) begin
      a  = int'($urandom_range(0, 255));
      b  = int'($urandom_range(0, 255));
      op = int'($urandom_range(0, 15));
      do_rst = (i >= 500 && i < 503);
      rst = do_rst;
      if (do_rst) begin
        res = 0; cy = 0; ovf = 0;
      end else begin
        ref_model(a, b, op, res, cy, ovf);
      end
      drive(8'(a), 8'(b), 4'(op));
      n_checks++;
      if (bus.result !== 8'(res) || bus.carry_out !== 1'(cy)) begin
        n_fail++;
        $display("FAIL b2b cycle %0d rst=%b op=%0h a=%h b=%h: result=%h carry=%b expected result=%h carry=%b",
                 i, do_rst, op, a[7:0], b[7:0], bus.result, bus.carry_out, res[7:0], cy[0]);
      end
`ifdef ALU_FLAGS_EN
      n_checks++;
      if (bus.zero_flag !== ((res == 0) && !do_rst) || bus.overflow_flag !== 1'(ovf)) begin
        n_fail++;
        $display("FAIL b2b flags cycle %0d: zero=%b ovf=%b expected zero=%b ovf=%b",
                 i, bus.zero_flag, bus.overflow_flag, (res == 0) && !do_rst, ovf[0]);
      end
`endif
    end
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    bus.operand_a = 8'h00;
    bus.operand_b = 8'h00;
    bus.operation = 4'h0;
    test_reset();
    test_directed();
    test_all_ops();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_8bit.md
ALU_8BIT -- requirements
Module: alu_8bit

Interface
- REQ-001 WIDTH, default 8, operand/result width; only 8 is supported.
- REQ-002 clk  input  1  single clock, all state updates on rising edge.
- REQ-003 rst  input  1  reset, synchronous, active-high.
- REQ-004 operand_a  input  8  operand A, unsigned.
- REQ-005 operand_b  input  8  operand B, unsigned.
- REQ-006 operation  input  4  opcode select.
- REQ-007 result  output  8  registered operation result.
- REQ-008 carry_out  output  1  registered carry/borrow/status bit.
- REQ-009 One clock; reset is synchronous and active-high, using ports clk and rst.

Function
- REQ-010 Inputs are sampled every rising clk edge, with no enable; result and carry_out reflect the inputs from the previous edge (latency 1 cycle, throughput 1 per cycle).
- REQ-011 0x0 ADD: {carry_out,result} = a+b (9-bit sum).
- REQ-012 0x1 SUB: result = a-b mod 256; carry_out = 1 when a<b (borrow).
- REQ-013 0x2 MUL: result = low byte of a*b; carry_out = 1 when the high byte is nonzero.
- REQ-014 0x3 DIV: result = a/b truncated, carry_out = 0; when b=0, result = 0xFF and carry_out = 1.
- REQ-015 0x4 SHL: result = a<<1, LSB 0, carry_out = a[7]; 0x5 SHR (logical): result = a>>1, carry_out = a[0].
- REQ-016 0x6 ROL: result = {a[6:0],a[7]}, carry_out = a[7]; 0x7 ROR: result = {a[0],a[7:1]}, carry_out = a[0].
- REQ-017 0x8 AND, 0x9 OR, 0xA XOR, 0xB NOR, 0xC NAND, 0xD XNOR are bitwise; carry_out = 0.
- REQ-018 0xE GT: result = 0x01 if a>b (unsigned), else 0x00; 0xF EQ: result = 0x01 if a==b, else 0x00; carry_out = 0.
- REQ-019 All 16 opcodes are defined; there is no illegal opcode and no X propagation from a valid opcode.
- REQ-020 Shift and rotate ops use operand_a only; operand_b is ignored.

Reset
- REQ-021 When rst=1 at a rising edge: result=0x00, carry_out=0, and all flag outputs are 0.
- REQ-022 Reset has priority over any operation sampled on the same edge.
- REQ-023 On the first edge after rst deasserts, the inputs present at that edge are computed normally; there is no extra idle cycle.

Configuration
- REQ-024 Macro ALU_FLAGS_EN: when defined, adds registered outputs zero_flag (1 bit, result==0x00) and overflow_flag (1 bit, two's-complement overflow for ADD/SUB, 0 for all other ops), both with latency 1 cycle and reset 0.
- REQ-025 Without ALU_FLAGS_EN, the zero_flag and overflow_flag ports and their logic are absent; all other behaviour is identical.

Structure
- REQ-026 Package alu_8bit_pkg holds the 4-bit opcode localparams/enum (OP_ADD..OP_EQ) and the WIDTH constant.
- REQ-027 Combinational datapath lives in sub-module alu_8bit_core (next result/carry/flags); alu_8bit holds only the output registers and reset.

Verification
- REQ-028 rst=1 for 2 cycles with a=0xFF, b=0xFF, op=0x0 -> result=0x00, carry_out=0.
- REQ-029 ADD a=0x33, b=0xCC -> next cycle result=0xFF, carry_out=0; ADD a=0xFF, b=0x01 -> result=0x00, carry_out=1 (zero_flag=1 with ALU_FLAGS_EN).
- REQ-030 SUB a=0x10, b=0x20 -> result=0xF0, carry_out=1; ADD a=0x7F, b=0x01 -> result=0x80, overflow_flag=1 with ALU_FLAGS_EN.
- REQ-031 MUL a=0x10, b=0x10 -> result=0x00, carry_out=1; DIV a=0x20, b=0x00 -> result=0xFF, carry_out=1; DIV a=0x64, b=0x07 -> result=0x0E, carry_out=0.
- REQ-032 SHL a=0x81 -> result=0x02, carry_out=1; ROR a=0x01 -> result=0x80, carry_out=1; EQ a=b=0x5A -> result=0x01; GT a=0x05, b=0x06 -> result=0x00.
- REQ-033 Back-to-back random a/b/op every cycle for 1000 cycles, with rst asserted mid-stream, -> outputs match a 1-cycle-delayed reference model, and reset wins on its edge.
